// File: rtl/segment_chaser_pkg.sv
// Mode codes and mode helpers shared by the segment chaser.
package segment_chaser_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MANUAL_FWD = 3'd0;
    localparam logic [MODE_W-1:0] MANUAL_BWD = 3'd1;
    localparam logic [MODE_W-1:0] OFF        = 3'd2;
    localparam logic [MODE_W-1:0] AUTO_FWD   = 3'd3;
    localparam logic [MODE_W-1:0] AUTO_BWD   = 3'd4;
    localparam logic [MODE_W-1:0] PINGPONG   = 3'd5;

    // Mode sequence on change requests; the unused codes fall back to MANUAL_FWD.
    function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
        return (m >= PINGPONG) ? MANUAL_FWD : m + 3'd1;
    endfunction

    // Modes driven by the tick timer.
    function automatic logic is_auto(input logic [MODE_W-1:0] m);
        return (m == AUTO_FWD) || (m == AUTO_BWD) || (m == PINGPONG);
    endfunction

    // Modes with the display blanked; unused codes behave as OFF.
    function automatic logic is_blank(input logic [MODE_W-1:0] m);
        return (m == OFF) || (m > PINGPONG);
    endfunction

endpackage

// File: rtl/segment_chaser_tick.sv
// Free-running step timer: one-cycle trigger every PERIOD enabled cycles.
module tick_timer #(
    parameter int unsigned PERIOD = 50_000_000
) (
    input  logic clk,
    input  logic async_nreset,
    input  logic clear,
    input  logic enable,
    output logic trigger
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    // Next count: clear beats a wrap, disabled holds at zero.
    always_comb begin
        count_next = count;
        if (clear || !enable) begin
            count_next = '0;
        end else if (count == LAST) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(1);
        end
    end

    // Counter register; trigger is registered alongside so it is high while count == LAST.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            count   <= '0;
            trigger <= 1'b0;
        end else begin
            count   <= count_next;
            trigger <= (count_next == LAST);
        end
    end

endmodule

// File: rtl/segment_chaser.sv
// Single-digit segment chaser: one lit segment moved manually or by timer.
module segment_chaser
    import segment_chaser_pkg::*;
#(
    parameter int unsigned SEGMENTS      = 6,
    parameter int unsigned DISPLAY_WIDTH = 8,
    parameter int unsigned TICK_PERIOD   = 50_000_000
) (
    input  logic                     clk,
    input  logic                     async_nreset,
    input  logic                     next_segment_re,
    input  logic                     change_mode_re,
    output logic [DISPLAY_WIDTH-1:0] display,
    output logic [MODE_W-1:0]        mode
);

    localparam int unsigned POS_W = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(SEGMENTS - 1);

    logic [POS_W-1:0]  pos;
    logic [POS_W-1:0]  pos_next;
    logic [POS_W-1:0]  pos_inc;
    logic [POS_W-1:0]  pos_dec;
    logic              dir;
    logic              dir_next;
    logic [MODE_W-1:0] mode_next;
    logic              timer_en;
    logic              tick;

    assign timer_en = is_auto(mode);

    // Every mode change request is accepted, so it always restarts the timer.
    tick_timer #(
        .PERIOD (TICK_PERIOD)
    ) u_tick_timer (
        .clk          (clk),
        .async_nreset (async_nreset),
        .clear        (change_mode_re),
        .enable       (timer_en),
        .trigger      (tick)
    );

    // Ring neighbours of the current position.
    assign pos_inc = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
    assign pos_dec = (pos == '0) ? POS_LAST : pos - POS_W'(1);

    // Next-state logic; a mode change drops any step in the same cycle.
    always_comb begin
        mode_next = mode;
        pos_next  = pos;
        dir_next  = dir;
        if (change_mode_re) begin
            mode_next = next_mode(mode);
            if (mode_next == PINGPONG) begin
                dir_next = 1'b1;
            end
        end else begin
            case (mode)
                MANUAL_FWD: if (next_segment_re) pos_next = pos_inc;
                MANUAL_BWD: if (next_segment_re) pos_next = pos_dec;
                AUTO_FWD:   if (tick) pos_next = pos_inc;
                AUTO_BWD:   if (tick) pos_next = pos_dec;
                PINGPONG: begin
                    if (tick) begin
                        if (dir) begin
                            pos_next = pos_inc;
                            if (pos == POS_LAST) begin
                                pos_next = pos_dec;
                                dir_next = 1'b0;
                            end
                        end else begin
                            pos_next = pos_dec;
                            if (pos == '0) begin
                                pos_next = pos_inc;
                                dir_next = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            mode <= MANUAL_FWD;
            pos  <= '0;
            dir  <= 1'b1;
        end else begin
            mode <= mode_next;
            pos  <= pos_next;
            dir  <= dir_next;
        end
    end

    // One-hot decode of the registered position, blanked in OFF.
    always_comb begin
        display = '0;
        if (!is_blank(mode)) begin
            display[pos] = 1'b1;
        end
    end

endmodule

// File: tb/tb_segment_chaser.sv
// Directed bench for segment_chaser with SEGMENTS=6, DISPLAY_WIDTH=8, TICK_PERIOD=4.
module tb_segment_chaser;

    logic       clk;
    logic       async_nreset;
    logic       next_segment_re;
    logic       change_mode_re;
    logic [7:0] display;
    logic [2:0] mode;

    int vectors;
    int errors;

    segment_chaser #(
        .SEGMENTS      (6),
        .DISPLAY_WIDTH (8),
        .TICK_PERIOD   (4)
    ) dut (
        .clk             (clk),
        .async_nreset    (async_nreset),
        .next_segment_re (next_segment_re),
        .change_mode_re  (change_mode_re),
        .display         (display),
        .mode            (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_next();
        next_segment_re = 1'b1;
        cyc(1);
        next_segment_re = 1'b0;
    endtask

    task automatic pulse_mode(input int n);
        change_mode_re = 1'b1;
        cyc(n);
        change_mode_re = 1'b0;
    endtask

    task automatic do_reset();
        async_nreset = 1'b0;
        #3;
        async_nreset = 1'b1;
        #1;
    endtask

    logic [7:0] fwd_exp [7];
    int         pp_pos  [11];

    initial begin
        vectors = 0;
        errors  = 0;
        fwd_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h01, 8'h02};
        pp_pos  = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
        async_nreset    = 1'b0;
        next_segment_re = 1'b0;
        change_mode_re  = 1'b0;

        // Reset state, held and after release.
        #12;
        check("rst_display", display, 8'h01);
        check("rst_mode", {5'b0, mode}, 8'h00);
        cyc(1);
        async_nreset = 1'b1;
        cyc(20);
        check("idle_display", display, 8'h01);
        check("idle_mode", {5'b0, mode}, 8'h00);

        // Manual forward with wrap.
        for (int i = 0; i < 7; i++) begin
            pulse_next();
            check($sformatf("fwd_%0d", i), display, fwd_exp[i]);
        end

        // Manual backward wrap from 0, then OFF and return.
        do_reset();
        pulse_mode(1);
        check("bwd_mode", {5'b0, mode}, 8'h01);
        pulse_next();
        check("bwd_wrap", display, 8'h20);
        pulse_mode(1);
        check("off_mode", {5'b0, mode}, 8'h02);
        check("off_blank", display, 8'h00);
        for (int i = 0; i < 3; i++) pulse_next();
        check("off_ignore", display, 8'h00);
        pulse_mode(4);
        check("wrap_mode", {5'b0, mode}, 8'h00);
        check("off_restore", display, 8'h20);

        // Back-to-back next pulses each step once (5 -> 0 -> 1 -> 2).
        next_segment_re = 1'b1;
        cyc(1);
        check("b2b_0", display, 8'h01);
        cyc(1);
        check("b2b_1", display, 8'h02);
        cyc(1);
        next_segment_re = 1'b0;
        check("b2b_2", display, 8'h04);

        // AUTO_FWD from pos 0; next requests ignored.
        do_reset();
        pulse_mode(3);
        check("afwd_mode", {5'b0, mode}, 8'h03);
        next_segment_re = 1'b1;
        cyc(3);
        check("afwd_k3", display, 8'h01);
        cyc(1);
        check("afwd_k4", display, 8'h02);
        cyc(3);
        check("afwd_k7", display, 8'h02);
        cyc(1);
        next_segment_re = 1'b0;
        check("afwd_k8", display, 8'h04);

        // PINGPONG bounce sequence.
        do_reset();
        pulse_mode(5);
        check("pp_mode", {5'b0, mode}, 8'h05);
        check("pp_start", display, 8'h01);
        for (int i = 0; i < 11; i++) begin
            cyc(4);
            check($sformatf("pp_%0d", i), display, 8'(1 << pp_pos[i]));
        end
        // Mode change coincident with a tick: mode wraps, pos stays 1.
        cyc(3);
        pulse_mode(1);
        check("pp_prio_mode", {5'b0, mode}, 8'h00);
        check("pp_prio_pos", display, 8'h02);
        cyc(8);
        check("pp_prio_hold", display, 8'h02);

        // Asynchronous reset mid-AUTO_BWD.
        do_reset();
        pulse_mode(4);
        check("abwd_mode", {5'b0, mode}, 8'h04);
        cyc(4);
        check("abwd_step", display, 8'h20);
        #2;
        async_nreset = 1'b0;
        #1;
        check("arst_display", display, 8'h01);
        check("arst_mode", {5'b0, mode}, 8'h00);
        #1;
        async_nreset = 1'b1;
        cyc(8);
        check("arst_hold", display, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/segment_chaser.md
# segment_chaser

Parametrised single-digit segment chaser for the board display path. Lights exactly one segment of a SEGMENTS-long ring and moves it manually (button edges) or automatically (internal tick timer) in forward, backward or ping-pong order, with a blanked mode. Sits between the edge-detected button inputs and the segment output pins; the generalised replacement for the fixed six-segment, four-mode driver.

## Interface
- SEGMENTS, 6: number of chased segments; legal range 2..DISPLAY_WIDTH.
- DISPLAY_WIDTH, 8: width of `display`; bits at SEGMENTS and above are always 0.
- TICK_PERIOD, 50_000_000: clk cycles between automatic steps; minimum 2.
- clk  input  1  clock.
- async_nreset  input  1  reset, asynchronous, active-low.
- next_segment_re  input  1  single-cycle pulse; manual step request.
- change_mode_re  input  1  single-cycle pulse; advance to next mode.
- display  output  DISPLAY_WIDTH  one-hot segment drive, active-high.
- mode  output  3  current mode code, for status LEDs.

## Operation
- State: `pos` (0..SEGMENTS-1), `mode` (3 bits), `dir` (1 = up), tick counter.
- Reset values: pos = 0, mode = MANUAL_FWD, dir = 1, counter = 0, display = 1 (bit 0), mode output = 0.
- Mode codes, in change_mode_re order, wrapping: MANUAL_FWD=0 -> MANUAL_BWD=1 -> OFF=2 -> AUTO_FWD=3 -> AUTO_BWD=4 -> PINGPONG=5 -> MANUAL_FWD. Codes 6 and 7 are unreachable; if decoded, they are treated as OFF and the next change_mode_re goes to MANUAL_FWD.
- MANUAL_FWD: on next_segment_re, pos = pos+1, with wrap from SEGMENTS-1 to 0. MANUAL_BWD: pos = pos-1, with wrap from 0 to SEGMENTS-1. Ticks ignored.
- OFF: display is all zero; pos and dir hold; next_segment_re is ignored. On leaving OFF, the previous pos is shown again.
- AUTO_FWD / AUTO_BWD: each tick steps pos as in the manual modes; next_segment_re is ignored.
- PINGPONG: on each tick, if dir = 1 then pos+1, else pos-1. At pos = SEGMENTS-1 with dir = 1, the tick sets pos to SEGMENTS-2 and dir to 0. At pos = 0 with dir = 0, the tick sets pos to 1 and dir to 1. dir is set to 1 on entry to PINGPONG.
- Priority: change_mode_re beats any step in the same cycle. Mode advances, pos is unchanged, and the tick or next request is dropped.
- Timer: enabled only in the AUTO_FWD, AUTO_BWD and PINGPONG modes. It is cleared to 0 on every accepted mode change and held at 0 in the other modes.
- Display: combinational decode of registered pos and mode. Bit pos is set unless mode is OFF.

## Timing
- A step request sampled at edge k updates pos at edge k. display shows the new value from edge k; there is no further latency.
- Tick: the counter runs 0..TICK_PERIOD-1 and wraps. The tick pulse is one cycle, asserted while counter = TICK_PERIOD-1.
- The first automatic step occurs TICK_PERIOD cycles after the mode-change edge, then every TICK_PERIOD cycles.
- Asynchronous reset mid-sequence immediately forces all reset values, including display = 1. The first step after reset release needs a new request or a full TICK_PERIOD.
- Back-to-back next_segment_re pulses on consecutive cycles each step once.

## Structure
- Package segment_chaser_pkg holds the mode localparams (MANUAL_FWD..PINGPONG) and the mode width, 3.
- One sub-module, tick_timer, with parameter PERIOD and ports clk, async_nreset, clear, enable, trigger. A clear in the same cycle as a wrap wins.
- The top level contains the mode/pos/dir FSM, the wrap arithmetic and the display decode. pos width is $clog2(SEGMENTS).

## Test plan
All scenarios use SEGMENTS=6, DISPLAY_WIDTH=8, TICK_PERIOD=4.
- Reset release -> display=8'h01, mode=0; 20 idle cycles -> unchanged.
- MANUAL_FWD, 7 next pulses -> display 02,04,08,10,20,01,02.
- One change_mode, then one next -> mode=1, display=8'h20; second change_mode -> display=8'h00. Next pulses are then ignored; after 4 further change_mode pulses (back to MANUAL_FWD) -> display=8'h20.
- AUTO_FWD entered at edge k from pos 0 -> display 02 at edge k+4, 04 at edge k+8; next pulses have no effect.
- PINGPONG -> sequence 0,1,2,3,4,5,4,3,2,1,0,1 every 4 cycles. A change_mode coincident with a tick -> mode becomes 0, pos unchanged.
- async_nreset asserted mid-AUTO_BWD -> display=8'h01 and mode=0 immediately, without waiting for a clk edge.
